// File: rtl/interrupt_controller_if.sv
// Request/acknowledge and status bundle between the interrupt controller and the core sequencer.
// The controller uses the slave modport; the core (or bench) drives through the master modport.
interface interrupt_controller_if #(
  parameter int unsigned NUM_INT = 4,
  parameter int unsigned ADDR_W  = 16
);
  localparam int unsigned IdW = $clog2(NUM_INT);

  logic [NUM_INT-1:0] int_in;
  logic               ei;
  logic               di;
  logic               reti;
  logic               mask_we;
  logic [NUM_INT-1:0] mask_din;
  logic               mode_we;
  logic [NUM_INT-1:0] mode_din;
  logic               int_ack;

  logic               irq;
  logic [ADDR_W-1:0]  vector;
  logic [IdW-1:0]     irq_id;
  logic               ie;
  logic [NUM_INT-1:0] pending;
  logic [NUM_INT-1:0] in_service;
  logic [NUM_INT-1:0] mask;

  modport master (
    output int_in, ei, di, reti, mask_we, mask_din, mode_we, mode_din, int_ack,
    input  irq, vector, irq_id, ie, pending, in_service, mask
  );

  modport slave (
    input  int_in, ei, di, reti, mask_we, mask_din, mode_we, mode_din, int_ack,
    output irq, vector, irq_id, ie, pending, in_service, mask
  );
endinterface

// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller: synchronised edge/level requests, mask, global enable, and a
// registered IRQ/vector to the core. Define INTC_NESTING_EN to allow nested servicing.
module interrupt_controller #(
  parameter int unsigned       NUM_INT    = 4,
  parameter int unsigned       ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(4),
  parameter int unsigned       VEC_STRIDE = 4
) (
  input logic                  clk,
  input logic                  rst,
  interrupt_controller_if.slave bus
);

  localparam int unsigned IdW = $clog2(NUM_INT);
`ifdef INTC_NESTING_EN
  localparam int unsigned StackD = NUM_INT;
`else
  localparam int unsigned StackD = 1;
`endif

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e              state_q, state_d;
  logic [NUM_INT-1:0]  sync1_q, sync2_q, sync3_q;
  logic [NUM_INT-1:0]  pending_q, pending_d;
  logic [NUM_INT-1:0]  mask_q, mask_d;
  logic [NUM_INT-1:0]  mode_q, mode_d;
  logic [NUM_INT-1:0]  isr_q, isr_d;
  logic                ie_q, ie_d;
  logic [StackD-1:0]   stack_q, stack_d;
  logic                irq_q, irq_d;
  logic [IdW-1:0]      id_q, id_d;
  logic [ADDR_W-1:0]   vec_q, vec_d;

  logic [NUM_INT-1:0]  rise;
  logic [NUM_INT-1:0]  eligible;
  logic [NUM_INT-1:0]  gate;
  logic [NUM_INT-1:0]  cand;
  logic                cand_valid;
  logic [IdW-1:0]      cand_id;
  logic                take;
  logic                reti_ok;

  // Two-flop synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= bus.int_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise = sync2_q & ~sync3_q;

  // Channel 0 (NMI) ignores both the global enable and its mask bit.
  always_comb begin
    eligible    = pending_q & mask_q & {NUM_INT{ie_q}};
    eligible[0] = pending_q[0];
  end

  always_comb begin
`ifdef INTC_NESTING_EN
    logic blocked;
    blocked = 1'b0;
    gate    = '0;
    for (int unsigned i = 0; i < NUM_INT; i++) begin
      blocked = blocked | isr_q[i];
      gate[i] = ~blocked;
    end
`else
    gate = {NUM_INT{~|isr_q}};
`endif
  end

  assign cand = eligible & gate;

  always_comb begin
    cand_valid = 1'b0;
    cand_id    = '0;
    for (int i = int'(NUM_INT) - 1; i >= 0; i--) begin
      if (cand[i]) begin
        cand_valid = 1'b1;
        cand_id    = IdW'(i);
      end
    end
  end

  // Request FSM: id and vector are frozen for the whole REQ state.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    vec_d   = vec_q;
    take    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cand_valid) begin
          state_d = StReq;
          id_d    = cand_id;
          vec_d   = VEC_BASE + ADDR_W'(cand_id) * ADDR_W'(VEC_STRIDE);
        end
      end
      StReq: begin
        if (bus.int_ack) begin
          state_d = StIdle;
          take    = 1'b1;
        end else if (bus.di && (id_q != '0)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign irq_d = (state_d == StReq);

  always_comb begin
    pending_d = pending_q;
    for (int unsigned i = 0; i < NUM_INT; i++) begin
      if (mode_q[i]) begin
        if (take && (id_q == IdW'(i))) pending_d[i] = 1'b0;
        if (rise[i]) pending_d[i] = 1'b1;
      end else begin
        pending_d[i] = sync2_q[i];
      end
    end
  end

  assign mask_d  = bus.mask_we ? (bus.mask_din & ~NUM_INT'(1)) : mask_q;
  assign mode_d  = bus.mode_we ? (bus.mode_din | NUM_INT'(1)) : mode_q;
  assign reti_ok = bus.reti && (|isr_q);

  // RETI is applied before ACK when both land in the same cycle; DI beats EI.
  always_comb begin
    isr_d   = isr_q;
    ie_d    = ie_q;
    stack_d = stack_q;
    if (reti_ok) begin
      isr_d   = isr_q & (isr_q - NUM_INT'(1));
      ie_d    = stack_q[0];
      stack_d = stack_q >> 1;
    end
    if (bus.ei) ie_d = 1'b1;
    if (bus.di) ie_d = 1'b0;
    if (take) begin
      isr_d[id_q] = 1'b1;
      stack_d     = (stack_d << 1) | StackD'(ie_d);
`ifndef INTC_NESTING_EN
      ie_d        = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      irq_q     <= 1'b0;
      id_q      <= '0;
      vec_q     <= VEC_BASE;
      pending_q <= '0;
      mask_q    <= '0;
      mode_q    <= '1;
      isr_q     <= '0;
      ie_q      <= 1'b0;
      stack_q   <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      id_q      <= id_d;
      vec_q     <= vec_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      isr_q     <= isr_d;
      ie_q      <= ie_d;
      stack_q   <= stack_d;
    end
  end

  assign bus.irq        = irq_q;
  assign bus.vector     = vec_q;
  assign bus.irq_id     = id_q;
  assign bus.ie         = ie_q;
  assign bus.pending    = pending_q;
  assign bus.in_service = isr_q;
  assign bus.mask       = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: NMI, mask/EI, priority, nesting, level hold, DI, reset.
module tb_interrupt_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  interrupt_controller_if #(.NUM_INT(4), .ADDR_W(16)) bus ();

  interrupt_controller #(
    .NUM_INT   (4),
    .ADDR_W    (16),
    .VEC_BASE  (16'h0004),
    .VEC_STRIDE(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    bus.int_in   = '0;
    bus.ei       = 1'b0;
    bus.di       = 1'b0;
    bus.reti     = 1'b0;
    bus.mask_we  = 1'b0;
    bus.mask_din = '0;
    bus.mode_we  = 1'b0;
    bus.mode_din = '0;
    bus.int_ack  = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.int_ack = 1'b1;
    step(1);
    bus.int_ack = 1'b0;
  endtask

  task automatic pulse_reti();
    bus.reti = 1'b1;
    step(1);
    bus.reti = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    nvec++; if (bus.irq !== 1'b0) begin nerr++; $display("FAIL reset_irq: got %b want 0", bus.irq); end
    nvec++; if (bus.vector !== 16'h0004) begin nerr++; $display("FAIL reset_vector: got %h want 0004", bus.vector); end
    nvec++; if (bus.irq_id !== 2'd0) begin nerr++; $display("FAIL reset_id: got %0d want 0", bus.irq_id); end
    nvec++; if (bus.ie !== 1'b0) begin nerr++; $display("FAIL reset_ie: got %b want 0", bus.ie); end
    nvec++; if (bus.mask !== 4'b0000) begin nerr++; $display("FAIL reset_mask: got %b want 0000", bus.mask); end
    nvec++; if (bus.pending !== 4'b0000) begin nerr++; $display("FAIL reset_pending: got %b want 0000", bus.pending); end
    nvec++; if (bus.in_service !== 4'b0000) begin nerr++; $display("FAIL reset_isr: got %b want 0000", bus.in_service); end
  endtask

  task automatic test_nmi();
    bus.int_in = 4'b0001;
    step(1);
    bus.int_in = 4'b0000;
    step(2);
    nvec++; if (bus.pending !== 4'b0001) begin nerr++; $display("FAIL nmi_pending: got %b want 0001", bus.pending); end
    nvec++; if (bus.irq !== 1'b0) begin nerr++; $display("FAIL nmi_irq_early: got %b want 0", bus.irq); end
    step(1);
    nvec++; if (bus.irq !== 1'b1) begin nerr++; $display("FAIL nmi_irq: got %b want 1", bus.irq); end
    nvec++; if (bus.vector !== 16'h0004) begin nerr++; $display("FAIL nmi_vector: got %h want 0004", bus.vector); end
    nvec++; if (bus.irq_id !== 2'd0) begin nerr++; $display("FAIL nmi_id: got %0d want 0", bus.irq_id); end
    pulse_ack();
    nvec++; if (bus.irq !== 1'b0) begin nerr++; $display("FAIL nmi_ack_irq: got %b want 0", bus.irq); end
    nvec++; if (bus.in_service !== 4'b0001) begin nerr++; $display("FAIL nmi_ack_isr: got %b want 0001", bus.in_service); end
    nvec++; if (bus.pending !== 4'b0000) begin nerr++; $display("FAIL nmi_ack_pending: got %b want 0000", bus.pending); end
    pulse_reti();
    nvec++; if (bus.in_service !== 4'b0000) begin nerr++; $display("FAIL nmi_reti_isr: got %b want 0000", bus.in_service); end
    nvec++; if (bus.ie !== 1'b0) begin nerr++; $display("FAIL nmi_reti_ie: got %b want 0", bus.ie); end
  endtask

  task automatic test_mask_ei();
    logic seen;
    bus.mask_we  = 1'b1;
    bus.mask_din = 4'b0010;
    step(1);
    bus.mask_we  = 1'b0;
    nvec++; if (bus.mask !== 4'b0010) begin nerr++; $display("FAIL mask_write: got %b want 0010", bus.mask); end
    bus.int_in = 4'b0010;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.irq === 1'b1) seen = 1'b1;
    end
    nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL mask_ie_off_irq: got %b want 0", seen); end
    nvec++; if (bus.pending !== 4'b0010) begin nerr++; $display("FAIL mask_pending: got %b want 0010", bus.pending); end
    bus.ei = 1'b1;
    step(1);
    bus.ei = 1'b0;
    nvec++; if (bus.ie !== 1'b1) begin nerr++; $display("FAIL ei_ie: got %b want 1", bus.ie); end
    step(1);
    nvec++; if (bus.irq !== 1'b1) begin nerr++; $display("FAIL ei_irq: got %b want 1", bus.irq); end
    nvec++; if (bus.vector !== 16'h0008) begin nerr++; $display("FAIL ei_vector: got %h want 0008", bus.vector); end
    pulse_ack();
    nvec++; if (bus.in_service !== 4'b0010) begin nerr++; $display("FAIL ei_ack_isr: got %b want 0010", bus.in_service); end
`ifdef INTC_NESTING_EN
    nvec++; if (bus.ie !== 1'b1) begin nerr++; $display("FAIL ei_ack_ie: got %b want 1", bus.ie); end
`else
    nvec++; if (bus.ie !== 1'b0) begin nerr++; $display("FAIL ei_ack_ie: got %b want 0", bus.ie); end
`endif
    pulse_reti();
    nvec++; if (bus.ie !== 1'b1) begin nerr++; $display("FAIL ei_reti_ie: got %b want 1", bus.ie); end
    bus.int_in = 4'b0000;
    step(3);
    nvec++; if (bus.irq !== 1'b0) begin nerr++; $display("FAIL ei_no_retrigger: got %b want 0", bus.irq); end
  endtask

  task automatic test_priority_nesting();
    bus.mask_we  = 1'b1;
    bus.mask_din = 4'b0110;
    step(1);
    bus.mask_we  = 1'b0;
    bus.int_in   = 4'b0110;
    step(4);
    bus.int_in   = 4'b0000;
    nvec++; if (bus.pending !== 4'b0110) begin nerr++; $display("FAIL prio_pending: got %b want 0110", bus.pending); end
    nvec++; if (bus.vector !== 16'h0008) begin nerr++; $display("FAIL prio_first_vector: got %h want 0008", bus.vector); end
    nvec++; if (bus.irq_id !== 2'd1) begin nerr++; $display("FAIL prio_first_id: got %0d want 1", bus.irq_id); end
    pulse_ack();
    step(1);
    nvec++; if (bus.irq !== 1'b0) begin nerr++; $display("FAIL prio_blocked: got %b want 0", bus.irq); end
    pulse_reti();
    step(1);
    nvec++; if (bus.irq !== 1'b1) begin nerr++; $display("FAIL prio_second_irq: got %b want 1", bus.irq); end
    nvec++; if (bus.vector !== 16'h000C) begin nerr++; $display("FAIL prio_second_vector: got %h want 000C", bus.vector); end
    pulse_ack();
    nvec++; if (bus.in_service !== 4'b0100) begin nerr++; $display("FAIL nest_isr2: got %b want 0100", bus.in_service); end
    bus.int_in = 4'b0010;
    step(1);
    bus.int_in = 4'b0000;
    step(3);
`ifdef INTC_NESTING_EN
    nvec++; if (bus.irq !== 1'b1) begin nerr++; $display("FAIL nest_irq: got %b want 1", bus.irq); end
    nvec++; if (bus.vector !== 16'h0008) begin nerr++; $display("FAIL nest_vector: got %h want 0008", bus.vector); end
    pulse_ack();
    nvec++; if (bus.in_service !== 4'b0110) begin nerr++; $display("FAIL nest_isr12: got %b want 0110", bus.in_service); end
    pulse_reti();
    nvec++; if (bus.in_service !== 4'b0100) begin nerr++; $display("FAIL nest_reti1: got %b want 0100", bus.in_service); end
    pulse_reti();
    nvec++; if (bus.in_service !== 4'b0000) begin nerr++; $display("FAIL nest_reti2: got %b want 0000", bus.in_service); end
`else
    nvec++; if (bus.irq !== 1'b0) begin nerr++; $display("FAIL nest_held_off: got %b want 0", bus.irq); end
    nvec++; if (bus.pending !== 4'b0010) begin nerr++; $display("FAIL nest_pending: got %b want 0010", bus.pending); end
    pulse_reti();
    nvec++; if (bus.in_service !== 4'b0000) begin nerr++; $display("FAIL nest_reti_isr: got %b want 0000", bus.in_service); end
    step(1);
    nvec++; if (bus.irq !== 1'b1) begin nerr++; $display("FAIL nest_after_reti_irq: got %b want 1", bus.irq); end
    nvec++; if (bus.vector !== 16'h0008) begin nerr++; $display("FAIL nest_after_reti_vec: got %h want 0008", bus.vector); end
    pulse_ack();
    pulse_reti();
    nvec++; if (bus.in_service !== 4'b0000) begin nerr++; $display("FAIL nest_final_isr: got %b want 0000", bus.in_service); end
`endif
    nvec++; if (bus.ie !== 1'b1) begin nerr++; $display("FAIL nest_final_ie: got %b want 1", bus.ie); end
  endtask

  task automatic test_level();
    logic seen;
    bus.mode_we  = 1'b1;
    bus.mode_din = 4'b0111;
    bus.mask_we  = 1'b1;
    bus.mask_din = 4'b1000;
    step(1);
    bus.mode_we  = 1'b0;
    bus.mask_we  = 1'b0;
    bus.int_in   = 4'b1000;
    step(4);
    nvec++; if (bus.irq !== 1'b1) begin nerr++; $display("FAIL level_irq: got %b want 1", bus.irq); end
    nvec++; if (bus.vector !== 16'h0010) begin nerr++; $display("FAIL level_vector: got %h want 0010", bus.vector); end
    bus.int_in = 4'b0000;
    step(3);
    nvec++; if (bus.pending !== 4'b0000) begin nerr++; $display("FAIL level_drop_pending: got %b want 0000", bus.pending); end
    nvec++; if (bus.irq !== 1'b1) begin nerr++; $display("FAIL level_hold_irq: got %b want 1", bus.irq); end
    nvec++; if (bus.irq_id !== 2'd3) begin nerr++; $display("FAIL level_hold_id: got %0d want 3", bus.irq_id); end
    pulse_ack();
    nvec++; if (bus.in_service !== 4'b1000) begin nerr++; $display("FAIL level_ack_isr: got %b want 1000", bus.in_service); end
    pulse_reti();
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (bus.irq === 1'b1) seen = 1'b1;
    end
    nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL level_no_reirq: got %b want 0", seen); end
  endtask

  task automatic test_di_and_async_reset();
    bus.mask_we  = 1'b1;
    bus.mask_din = 4'b0010;
    step(1);
    bus.mask_we  = 1'b0;
    bus.int_in   = 4'b0010;
    step(1);
    bus.int_in   = 4'b0000;
    step(3);
    nvec++; if (bus.irq_id !== 2'd1) begin nerr++; $display("FAIL di_setup_id: got %0d want 1", bus.irq_id); end
    bus.di = 1'b1;
    step(1);
    bus.di = 1'b0;
    nvec++; if (bus.irq !== 1'b0) begin nerr++; $display("FAIL di_irq: got %b want 0", bus.irq); end
    nvec++; if (bus.pending !== 4'b0010) begin nerr++; $display("FAIL di_pending: got %b want 0010", bus.pending); end
    nvec++; if (bus.ie !== 1'b0) begin nerr++; $display("FAIL di_ie: got %b want 0", bus.ie); end
    bus.ei = 1'b1;
    step(1);
    bus.ei = 1'b0;
    step(1);
    nvec++; if (bus.irq !== 1'b1) begin nerr++; $display("FAIL rst_setup_irq: got %b want 1", bus.irq); end
    rst = 1'b1;
    #1;
    nvec++; if (bus.irq !== 1'b0) begin nerr++; $display("FAIL rst_async_irq: got %b want 0", bus.irq); end
    nvec++; if (bus.pending !== 4'b0000) begin nerr++; $display("FAIL rst_pending: got %b want 0000", bus.pending); end
    nvec++; if (bus.mask !== 4'b0000) begin nerr++; $display("FAIL rst_mask: got %b want 0000", bus.mask); end
    nvec++; if (bus.ie !== 1'b0) begin nerr++; $display("FAIL rst_ie: got %b want 0", bus.ie); end
    nvec++; if (bus.vector !== 16'h0004) begin nerr++; $display("FAIL rst_vector: got %h want 0004", bus.vector); end
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_nmi();
    test_mask_ei();
    test_priority_nesting();
    test_level();
    test_di_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Parametrised, prioritised interrupt controller between external interrupt pins and the processor core's sequencer. It synchronises NUM_INT request lines, latches edge or level requests, applies a global enable and per-channel mask, and presents a single registered request with a computed vector address to the core. The core acknowledges the request at an instruction boundary and reports RETI/EI/DI from decode. Channel 0 is a non-maskable interrupt (NMI) and vectors to 0x0004; channel 1 vectors to 0x0008.

## Interface
- NUM_INT, 4, number of interrupt channels (2..16); channel 0 is the NMI.
- ADDR_W, 16, vector width.
- VEC_BASE, 16'h0004, vector of channel 0.
- VEC_STRIDE, 4, byte distance between consecutive channel vectors.
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- INT_IN  in  NUM_INT  asynchronous request pins, active-high.
- EI, DI, RETI  in  1 each  one-cycle pulses from instruction execute.
- MASK_WE  in  1  writes MASK_DIN to the mask register.
- MASK_DIN  in  NUM_INT  1 = channel enabled; bit 0 is ignored.
- MODE_WE  in  1  writes MODE_DIN to the mode register.
- MODE_DIN  in  NUM_INT  1 = edge-triggered, 0 = level; bit 0 is forced to 1.
- INT_ACK  in  1  one-cycle pulse: the core has taken VECTOR this cycle.
- IRQ  out  1  request to the core; registered.
- VECTOR  out  ADDR_W  VEC_BASE + IRQ_ID*VEC_STRIDE; registered, stable while IRQ=1.
- IRQ_ID  out  clog2(NUM_INT)  channel being requested.
- IE  out  1  global enable.
- PENDING, IN_SERVICE, MASK  out  NUM_INT each  status registers.

## Operation
- Each INT_IN bit passes through a 2-flop synchroniser. Edge channels set PENDING on a synced 0->1 transition. Level channels have PENDING equal to the synced level.
- Eligible(i) = PENDING[i] & (i==0 | (IE & MASK[i])). The lowest index has the highest priority.
- States: IDLE, REQ.
  - IDLE->REQ when the highest-priority eligible channel passes the nesting gate (see Configuration). On entry, IRQ=1 and IRQ_ID/VECTOR are latched.
  - In REQ, IRQ_ID and VECTOR stay frozen until ACK, even if a higher-priority request arrives or a level source drops.
  - REQ->IDLE on INT_ACK. On that edge: clear PENDING[id] for edge channels; set IN_SERVICE[id]; push the current IE onto a NUM_INT-deep IE-save stack; clear IE if nesting is off. IRQ falls on the same edge.
  - REQ->IDLE on DI when IRQ_ID!=0. The request is withdrawn and PENDING is kept.
- RETI clears the lowest-index set IN_SERVICE bit and pops the IE-save stack into IE. RETI with IN_SERVICE=0 is ignored.
- EI sets IE; DI clears it. If both occur in the same cycle, DI wins.
- If RETI and INT_ACK occur in the same cycle, RETI is applied first, then ACK.
- An edge that arrives while PENDING[i]=1 is merged; there is no counting.
- MASK/MODE writes take effect on the next eligibility evaluation.
- Reset values: IRQ=0, VECTOR=VEC_BASE, IRQ_ID=0, IE=0, MASK=0, MODE=all 1, PENDING=0, IN_SERVICE=0, stack empty, synchronisers 0, state IDLE. Reset mid-REQ drops IRQ asynchronously.

## Timing
- A pin rising edge captured at edge N sets PENDING at N+2 (edge mode) or follows the level from N+2 (level mode). IRQ and VECTOR are valid at N+3.
- ACK to the next IRQ takes at least 1 idle cycle.
- RETI to a re-evaluated IRQ takes 1 cycle.
- EI enabling an already-pending channel raises IRQ 1 cycle after the EI edge.
- No combinational path exists from any input to IRQ, VECTOR or IRQ_ID.

## Configuration
- INTC_NESTING_EN defined:
  - IE is not cleared on ACK.
  - A request passes the nesting gate only if its index is lower than the lowest set IN_SERVICE bit, or IN_SERVICE=0.
  - IN_SERVICE and the IE stack can hold up to NUM_INT levels.
- INTC_NESTING_EN undefined:
  - IE is cleared on ACK.
  - The nesting gate is IN_SERVICE==0. This applies to the NMI as well.
  - The stack depth is 1.

## Test plan
- Reset, then INT_IN[0] pulse with IE=0 -> IRQ=1, VECTOR=0x0004, IRQ_ID=0 at edge+3. ACK -> IN_SERVICE=0001, PENDING[0]=0. RETI -> IN_SERVICE=0, IE=0.
- INT_IN[1] high with IE=0, MASK=0010 -> IRQ stays 0 for 20 cycles and PENDING[1]=1. Then EI -> IRQ=1 one cycle later, VECTOR=0x0008.
- INT_IN[1] and INT_IN[2] raised in the same cycle, IE=1, MASK=0110 -> VECTOR=0x0008 first. After ACK and RETI -> VECTOR=0x000C.
- Nesting: ACK channel 2, then pulse INT_IN[1].
  - With INTC_NESTING_EN: IRQ with VECTOR=0x0008. The two RETIs clear IN_SERVICE bits 1 then 2, and IE ends at 1.
  - Without INTC_NESTING_EN: no IRQ until RETI.
- Level channel 3 (MODE=0111, MASK=1000, IE=1): the level drops before ACK -> IRQ and VECTOR=0x0010 are held. ACK and RETI follow, and no further IRQ occurs.
- RESET asserted mid-REQ -> IRQ=0 asynchronously and all registers return to their reset values. DI in REQ on channel 1 -> IRQ falls next edge and PENDING[1] remains 1.
